apb_req_arbiter: RTL

//  Shares one APB add-master between NUM_REQ requesters using round-robin arbitration.

---
 rtl/apb_req_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that shares one APB master between NUM_REQ requesters.
// One transfer in flight at a time; completion is taken from the snooped APB bus.
module apb_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        we_i,
    input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        done_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic [1:0]                cmd_o,
    output logic [DATA_W-1:0]         wdata_o,
    input  logic                      psel_i,
    input  logic                      penable_i,
    input  logic                      pready_i,
    input  logic [DATA_W-1:0]         prdata_i,
    output logic                      busy_o,
    output logic                      timeout_o
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int WD_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   pick;
    logic [PTR_W-1:0]   cand;
    logic [PTR_W:0]     sum;
    logic               pick_vld;
    logic               we_lat;
    logic [WD_W-1:0]    wd_cnt;
    logic               xfer_done;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

    assign xfer_done = psel_i & penable_i & pready_i;
    assign busy_o    = (state != IDLE);

    // Walk downward so the last hit wins: that is the set bit closest to ptr.
    always_comb begin
        pick     = ptr;
        pick_vld = 1'b0;
        sum      = '0;
        cand     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (PTR_W + 1)'(i);
            if (sum >= (PTR_W + 1)'(NUM_REQ))
                sum = sum - (PTR_W + 1)'(NUM_REQ);
            cand = sum[PTR_W-1:0];
            if (req_i[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        gnt_o     = '0;
        done_o    = '0;
        cmd_o     = 2'b00;
        case (state)
            IDLE: begin
                if (pick_vld)
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                cmd_o     = {we_lat, 1'b1};
                gnt_o     = onehot(owner);
                state_nxt = WAIT;
            end
            WAIT: begin
                if (xfer_done)
                    state_nxt = DONE;
            end
            DONE: begin
                done_o    = onehot(owner);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Transfer context, read capture, rotation pointer and watchdog.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            ptr       <= '0;
            owner     <= '0;
            we_lat    <= 1'b0;
            wdata_o   <= '0;
            rdata_o   <= '0;
            wd_cnt    <= '0;
            timeout_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        owner   <= pick;
                        we_lat  <= we_i[pick];
                        wdata_o <= wdata_i[pick*DATA_W +: DATA_W];
                    end
                end
                ISSUE: begin
                    wd_cnt <= '0;
                end
                WAIT: begin
                    if (xfer_done && !we_lat)
                        rdata_o <= prdata_i;
                    // The master cannot abort, so the watchdog only flags and saturates.
                    if (TIMEOUT != 0 && wd_cnt != WD_W'(TIMEOUT)) begin
                        wd_cnt <= wd_cnt + 1'b1;
                        if (wd_cnt == WD_W'(TIMEOUT - 1))
                            timeout_o <= 1'b1;
                    end
                end
                DONE: begin
                    ptr <= (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
